// File: rtl/rsa_operand_loader.sv
// Streams an operand in CHUNK-bit pieces (LSB first) and commits it into the A, B or M register.
// Optional readback path enabled by defining RSA_LOADER_READBACK_EN.
module rsa_operand_loader #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       dest,
  input  logic [CHUNK-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic [WIDTH-1:0] m_out,
  input  logic             rd_start,
  input  logic [1:0]       rd_sel,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic [CHUNK-1:0] rd_data
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    DEST_A   = 2'b00,
    DEST_B   = 2'b01,
    DEST_M   = 2'b10,
    DEST_CLR = 2'b11
  } dest_e;

  state_e           state_q, state_d;
  logic [1:0]       dest_q, dest_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, m_q, m_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] word;

  assign in_ready = (state_q == LOAD) && !start;
  assign busy     = (state_q == LOAD);
  assign done     = done_q;
  assign a_out    = a_q;
  assign b_out    = b_q;
  assign m_out    = m_q;
  assign word     = {in_data, shreg_q[WIDTH-1:CHUNK]};

  // NOTE: every variable gets a default at the top of always_comb so that no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    done_d  = 1'b0;

    // start behaves identically in both states; in LOAD it also drops the partial word.
    if (start) begin
      if (dest == DEST_CLR) begin
        a_d     = '0;
        b_d     = '0;
        m_d     = '0;
        done_d  = 1'b1;
        state_d = IDLE;
      end else begin
        dest_d  = dest;
        shreg_d = '0;
        cnt_d   = '0;
        state_d = LOAD;
      end
    end else if (state_q == LOAD && in_valid) begin
      shreg_d = word;
      cnt_d   = cnt_q + CW'(1);
      if (cnt_q == LAST) begin
        cnt_d   = '0;
        done_d  = 1'b1;
        state_d = IDLE;
        case (dest_q)
          DEST_A:  a_d = word;
          DEST_B:  b_d = word;
          DEST_M:  m_d = word;
          default: ;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dest_q  <= '0;
      shreg_q <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      done_q  <= done_d;
    end
  end

`ifdef RSA_LOADER_READBACK_EN
  logic [WIDTH-1:0] rd_sh_q, rd_sh_d;
  logic [CW-1:0]    rd_cnt_q, rd_cnt_d;
  logic             rd_valid_q, rd_valid_d;
  logic [WIDTH-1:0] rd_snap;

  always_comb begin
    case (rd_sel)
      DEST_A:  rd_snap = a_q;
      DEST_B:  rd_snap = b_q;
      DEST_M:  rd_snap = m_q;
      default: rd_snap = '0;
    endcase
  end

  // The snapshot is private, so later commits cannot disturb a readback in flight.
  always_comb begin
    rd_sh_d    = rd_sh_q;
    rd_cnt_d   = rd_cnt_q;
    rd_valid_d = rd_valid_q;
    if (rd_start) begin
      rd_sh_d    = rd_snap;
      rd_cnt_d   = '0;
      rd_valid_d = 1'b1;
    end else if (rd_valid_q && rd_ready) begin
      rd_sh_d  = rd_sh_q >> CHUNK;
      rd_cnt_d = rd_cnt_q + CW'(1);
      if (rd_cnt_q == LAST) begin
        rd_cnt_d   = '0;
        rd_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_sh_q    <= '0;
      rd_cnt_q   <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_sh_q    <= rd_sh_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_valid_q ? rd_sh_q[CHUNK-1:0] : '0;
`else
  logic unused_rd;
  assign unused_rd = ^{rd_start, rd_sel, rd_ready};
  assign rd_valid  = 1'b0;
  assign rd_data   = '0;
`endif

endmodule

// File: tb/tb_rsa_operand_loader.sv
// Directed, table-driven bench for rsa_operand_loader (WIDTH=8, CHUNK=2).
// Readback sequence is checked when RSA_LOADER_READBACK_EN is defined.
module tb_rsa_operand_loader;

  localparam int WIDTH = 8;
  localparam int CHUNK = 2;
  localparam int N     = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [1:0]       dest;
  logic [CHUNK-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] a_out, b_out, m_out;
  logic             rd_start;
  logic [1:0]       rd_sel;
  logic             rd_ready;
  logic             rd_valid;
  logic [CHUNK-1:0] rd_data;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;

  rsa_operand_loader #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .dest     (dest),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .busy     (busy),
    .done     (done),
    .a_out    (a_out),
    .b_out    (b_out),
    .m_out    (m_out),
    .rd_start (rd_start),
    .rd_sel   (rd_sel),
    .rd_ready (rd_ready),
    .rd_valid (rd_valid),
    .rd_data  (rd_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_cnt++;

  typedef struct {
    logic [1:0] dest;
    logic [7:0] word;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
    logic [7:0] exp_m;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_cmd(input logic [1:0] d);
    start = 1'b1;
    dest  = d;
    tick();
    start = 1'b0;
  endtask

  // Sends chunks first..last of w, with `gap` idle cycles before each one.
  task automatic send_chunks(input logic [7:0] w, input int first, input int last, input int gap);
    for (int i = first; i <= last; i++) begin
      in_valid = 1'b0;
      for (int g = 0; g < gap; g++) tick();
      in_valid = 1'b1;
      in_data  = w[i*CHUNK +: CHUNK];
      tick();
    end
    in_valid = 1'b0;
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{dest: 2'b00, word: 8'h39, exp_a: 8'h39, exp_b: 8'h00, exp_m: 8'h00};
    vecs[1] = '{dest: 2'b01, word: 8'hA5, exp_a: 8'h39, exp_b: 8'hA5, exp_m: 8'h00};
    vecs[2] = '{dest: 2'b10, word: 8'h5C, exp_a: 8'h39, exp_b: 8'hA5, exp_m: 8'h5C};
    vecs[3] = '{dest: 2'b00, word: 8'hFF, exp_a: 8'hFF, exp_b: 8'hA5, exp_m: 8'h5C};
    vecs[4] = '{dest: 2'b11, word: 8'h00, exp_a: 8'h00, exp_b: 8'h00, exp_m: 8'h00};
    vecs[5] = '{dest: 2'b10, word: 8'h81, exp_a: 8'h00, exp_b: 8'h00, exp_m: 8'h81};

    rst_n = 1'b0; start = 1'b0; dest = 2'b00; in_data = '0; in_valid = 1'b0;
    rd_start = 1'b0; rd_sel = 2'b00; rd_ready = 1'b0;
    #12;
    check("rst_a", a_out, 0);
    check("rst_b", b_out, 0);
    check("rst_m", m_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    rst_n = 1'b1;
    tick();
    check("idle_in_ready", in_ready, 0);

    // Table: continuous streams plus one clear.
    for (int v = 0; v < 6; v++) begin
      if (vecs[v].dest == 2'b11) begin
        start = 1'b1; dest = 2'b11;
        tick();
        start = 1'b0;
        check("clr_busy", busy, 0);
      end else begin
        start_cmd(vecs[v].dest);
        check("load_busy", busy, 1);
        send_chunks(vecs[v].word, 0, N-2, 0);
        check("pre_done", done, 0);
        send_chunks(vecs[v].word, N-1, N-1, 0);
      end
      check($sformatf("vec%0d_done", v), done, 1);
      check($sformatf("vec%0d_a", v), a_out, vecs[v].exp_a);
      check($sformatf("vec%0d_b", v), b_out, vecs[v].exp_b);
      check($sformatf("vec%0d_m", v), m_out, vecs[v].exp_m);
      tick();
      check($sformatf("vec%0d_done_drop", v), done, 0);
    end

    // Gapped load of B, a_out preloaded with 8'h39.
    start_cmd(2'b00); send_chunks(8'h39, 0, N-1, 0); tick();
    start_cmd(2'b01);
    send_chunks(8'hA5, 0, 0, 1);
    send_chunks(8'hA5, 1, 1, 2);
    send_chunks(8'hA5, 2, 2, 3);
    check("gap_b_before_last", b_out, 8'h00);
    send_chunks(8'hA5, 3, 3, 1);
    check("gap_b", b_out, 8'hA5);
    check("gap_a_kept", a_out, 8'h39);
    check("gap_done", done, 1);
    tick();

    // Abort an M load after two chunks by restarting toward B.
    done_cnt = 0;
    start_cmd(2'b10);
    send_chunks(8'h77, 0, 1, 0);
    start = 1'b1; dest = 2'b01; in_valid = 1'b1; in_data = 2'b11;
    #1;
    check("abort_in_ready", in_ready, 0);
    tick();
    start = 1'b0; in_valid = 1'b0;
    send_chunks(8'h0F, 0, N-1, 0);
    check("abort_m_kept", m_out, 8'h81);
    check("abort_b", b_out, 8'h0F);
    tick();
    check("abort_single_done", done_cnt, 1);

    // Back-to-back: start asserted in the done cycle.
    start_cmd(2'b10); send_chunks(8'h3C, 0, N-1, 0);
    check("b2b_done1", done, 1);
    start_cmd(2'b00);
    send_chunks(8'hC6, 0, N-1, 0);
    check("b2b_m", m_out, 8'h3C);
    check("b2b_a", a_out, 8'hC6);
    tick();

    // Asynchronous reset in the middle of a load.
    start_cmd(2'b01);
    send_chunks(8'hE4, 0, 2, 0);
    in_valid = 1'b1; in_data = 2'b11;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_a", a_out, 0);
    check("arst_b", b_out, 0);
    check("arst_m", m_out, 0);
    check("arst_busy", busy, 0);
    #3;
    rst_n = 1'b1;
    in_valid = 1'b0;
    tick();
    check("arst_idle_busy", busy, 0);
    check("arst_idle_in_ready", in_ready, 0);
    check("arst_b_after", b_out, 0);

`ifdef RSA_LOADER_READBACK_EN
    begin
      logic [CHUNK-1:0] got[N];
      logic [7:0]       expw;
      int               n_got;
      expw = 8'h39;
      start_cmd(2'b00); send_chunks(8'h39, 0, N-1, 0); tick();
      rd_sel = 2'b00; rd_start = 1'b1;
      tick();
      rd_start = 1'b0;
      n_got = 0;
      for (int c = 0; c < 40 && n_got < N; c++) begin
        rd_ready = c[0];
        #1;
        if (rd_valid && rd_ready) begin
          got[n_got] = rd_data;
          n_got++;
        end
        tick();
      end
      rd_ready = 1'b0;
      check("rd_count", n_got, N);
      for (int i = 0; i < N; i++)
        check($sformatf("rd_piece%0d", i), got[i], expw[i*CHUNK +: CHUNK]);
      check("rd_valid_end", rd_valid, 0);
    end
`else
    begin
      logic seen;
      seen = 1'b0;
      rd_sel = 2'b00; rd_start = 1'b1; rd_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
        tick();
        rd_start = 1'b0;
        if (rd_valid !== 1'b0) seen = 1'b1;
      end
      rd_ready = 1'b0;
      check("rd_disabled", seen, 0);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rsa_operand_loader.md
# rsa_operand_loader

Write-side companion to the RSA datapath operand multiplexer. It accepts an operand as a stream of CHUNK-bit pieces over a valid/ready handshake and assembles them into a WIDTH-bit word. It then commits the word into one of three operand registers (A, B, M), selected by a 2-bit destination, or clears all three. The registered operands feed the datapath muxes directly.

## Interface
Parameters:
- WIDTH, 8: operand width in bits.
- CHUNK, 2: bits per transferred piece. WIDTH % CHUNK == 0 and WIDTH >= 2*CHUNK are required. N = WIDTH/CHUNK.

Ports:
- clk  input  1  sole clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a load (or clear) toward dest
- dest  input  2  00=A, 01=B, 10=M, 11=clear all
- in_data  input  CHUNK  operand piece, LSB piece first
- in_valid  input  1  in_data valid
- in_ready  output  1  loader accepts in_data this cycle
- busy  output  1  load in progress
- done  output  1  one-cycle pulse after commit or clear
- a_out, b_out, m_out  output  WIDTH each  operand registers
- rd_start  input  1  begin readback (feature-gated)
- rd_sel  input  2  00=A, 01=B, 10=M, 11=all-zero word
- rd_ready  input  1  consumer accepts rd_data
- rd_valid  output  1  rd_data valid
- rd_data  output  CHUNK  readback piece, LSB piece first

## Operation
- States: IDLE, LOAD.
- IDLE:
  - in_ready=0; chunks are ignored.
  - start with dest 00/01/10 latches dest, clears the shift register and counter, then enters LOAD.
  - start with dest=11 zeroes a_out, b_out and m_out on that edge, pulses done next cycle, and stays in IDLE.
- LOAD:
  - busy=1. in_ready = !start (combinational).
  - Each handshake (in_valid & in_ready) shifts right: shreg <= {in_data, shreg[WIDTH-1:CHUNK]}; count increments.
  - On the handshake with count==N-1, the edge writes {in_data, shreg[WIDTH-1:CHUNK]} into the latched target and returns to IDLE. done is high for the following cycle only.
  - Gaps in in_valid stall without timeout.
- start while in LOAD aborts the partial word. The target is not written, the new dest is latched, and the counter is cleared; dest=11 clears the registers and returns to IDLE. A chunk presented in that same cycle is not accepted.
- Non-target registers never change during a load.
- Reset:
  - Asynchronous; a reset mid-load discards the partial word.
  - Reset values: state IDLE, all operand registers 0, shreg 0, count 0, in_ready 0, busy 0, done 0, rd_valid 0, rd_data 0.

## Timing
- Load of N chunks with in_valid held high: start at cycle 0, handshakes at cycles 1..N, register updated at the edge ending cycle N, done high in cycle N+1.
- Minimum back-to-back: start may be asserted in the done cycle.
- in_ready depends combinationally on start and state only, never on in_valid.
- Operand outputs are registered with no combinational path from inputs.

## Configuration
- Macro: RSA_LOADER_READBACK_EN.
- Defined:
  - rd_start snapshots the register chosen by rd_sel into a read shift register. rd_valid rises the next cycle and presents the LSB piece.
  - Each rd_valid & rd_ready shifts out the next piece. After the N-th handshake, rd_valid drops.
  - rd_start during an active readback restarts from a new snapshot.
  - Commits made during a readback do not alter the snapshot.
- Undefined: rd_start, rd_sel and rd_ready are ignored; rd_valid and rd_data are tied 0. Ports remain present.

## Test plan
- Reset, then start dest=00 with chunks 01,10,11,00 streamed continuously -> a_out=8'h39, b_out=m_out=0, done high exactly one cycle after the 4th handshake.
- Load B with 8'hA5 using in_valid gaps of 1-3 cycles -> b_out=8'hA5, only after the 4th accepted chunk; a_out unchanged.
- Load M, assert start dest=01 after 2 chunks, then send 4 chunks for 8'h0F -> m_out keeps its old value, b_out=8'h0F, a single done.
- Load A,B,M with nonzero values, then start dest=11 -> all three are 0 on the next edge, done pulses, busy never rises.
- Assert rst_n=0 asynchronously after 3 chunks -> outputs are 0 immediately; after release the loader is IDLE and in_ready=0.
- With RSA_LOADER_READBACK_EN defined and a_out=8'h39: rd_start rd_sel=00, rd_ready toggling -> rd_data sequence 01,10,11,00, then rd_valid=0. Without the macro, rd_valid stays 0.
